// File: rtl/muxn_1_reg.sv
// N-to-1 registered mux with valid/ready handshake on every channel and on the output.
// Define MUXN_RR_EN for round-robin arbitration; the default build uses fixed selection via s.
module muxn_1_reg #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SW-1:0]   s,
  input  logic [N*W-1:0]  in_bus,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic [SW-1:0]   y_ch
);

  logic          slot_free;
  logic          grant_ok;
  logic          xfer;
  logic [SW-1:0] g;
  logic [W-1:0]  g_data;

  assign slot_free = !y_valid || y_ready;

`ifdef MUXN_RR_EN
  logic [SW-1:0] ptr;
  int unsigned   best;
  int unsigned   dist;

  // Pick the valid channel closest above ptr (mod N); distance 0 is ptr+1.
  always_comb begin
    g        = '0;
    grant_ok = 1'b0;
    best     = N;
    dist     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      dist = (i + N - 1 - 32'(ptr)) % N;
      if (in_valid[i] && dist < best) begin
        best     = dist;
        g        = SW'(i);
        grant_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= SW'(N - 1);
    else if (xfer)
      ptr <= g;
  end
`else
  always_comb begin
    g        = s;
    grant_ok = (32'(s) < N);
  end
`endif

  always_comb begin
    g_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (g == SW'(i))
        g_data = in_bus[i*W +: W];
    end
  end

  // Gated by rst_n so in_ready reads zero throughout reset even though the slot looks free.
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < N; i++) begin
      in_ready[i] = rst_n && slot_free && grant_ok && (g == SW'(i));
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
    end else if (xfer) begin
      y       <= g_data;
      y_ch    <= g;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxn_1_reg.sv
// Randomized and directed bench for muxn_1_reg against a transaction-level reference model.
// Second instance with N=3 exercises the out-of-range select.
module tb_muxn_1_reg;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   s;
  logic [127:0] in_bus;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [31:0]  y;
  logic         y_valid;
  logic         y_ready;
  logic [1:0]   y_ch;

  logic [1:0]   s3;
  logic [23:0]  bus3;
  logic [2:0]   v3;
  logic [2:0]   rdy3;
  logic [7:0]   y3;
  logic         yv3;
  logic         yr3;
  logic [1:0]   ych3;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_valid;
  logic [31:0] m_y;
  logic [1:0]  m_ch;
  int          m_ptr;

  always #5 clk = ~clk;

  muxn_1_reg #(.W(32), .N(4), .SW(2)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .in_bus(in_bus), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_ch(y_ch)
  );

  muxn_1_reg #(.W(8), .N(3), .SW(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .s(s3), .in_bus(bus3), .in_valid(v3),
    .in_ready(rdy3), .y(y3), .y_valid(yv3), .y_ready(yr3), .y_ch(ych3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = '0;
    m_ch    = '0;
    m_ptr   = 3;
  endtask

  task automatic pick(input logic [1:0] s_v, input logic [3:0] v_v, output int g, output bit ok);
`ifdef MUXN_RR_EN
    g  = 0;
    ok = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!ok && v_v[(m_ptr + k) % 4]) begin
        g  = (m_ptr + k) % 4;
        ok = 1'b1;
      end
    end
`else
    g  = int'(s_v);
    ok = (g < 4);
`endif
  endtask

  task automatic check_out();
    check("y_valid", y_valid, m_valid);
    check("y", y, m_y);
    check("y_ch", y_ch, m_ch);
  endtask

  task automatic step(input logic [1:0] s_v, input logic [3:0] v_v, input logic yr_v,
                      input logic [127:0] bus_v);
    int         g;
    bit         ok;
    bit         free;
    bit         xf;
    logic [3:0] rdy;
    @(negedge clk);
    s = s_v; in_valid = v_v; y_ready = yr_v; in_bus = bus_v;
    free = !m_valid || yr_v;
    pick(s_v, v_v, g, ok);
    rdy = (free && ok) ? 4'(1 << g) : 4'b0000;
    #1 check("in_ready", in_ready, rdy);
    xf = ok && free && v_v[g];
    @(posedge clk);
    #1;
    if (xf) begin
      m_y     = bus_v[g*32 +: 32];
      m_ch    = 2'(g);
      m_valid = 1'b1;
      m_ptr   = g;
    end else if (yr_v) begin
      m_valid = 1'b0;
    end
    check_out();
  endtask

  initial begin
    logic [127:0] ramp;
    logic [127:0] bp;
    ramp = {32'd3, 32'd2, 32'd1, 32'd0};
    bp   = {32'h0, 32'hA5A5_0002, 32'h0, 32'h0};

    rst_n = 1'b0; s = '0; in_bus = ramp; in_valid = 4'hF; y_ready = 1'b1;
    s3 = '0; bus3 = '0; v3 = '0; yr3 = 1'b1;
    model_reset();
    #12;
    check("rst_y_valid", y_valid, 1'b0);
    check("rst_y", y, 32'h0);
    check("rst_y_ch", y_ch, 2'h0);
    check("rst_in_ready", in_ready, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    // Stepping select with all channels valid: full throughput
    for (int i = 0; i < 4; i++) step(2'(i), 4'hF, 1'b1, ramp);

    // Backpressure: hold for three cycles, then one beat drains
    step(2'd2, 4'b0100, 1'b0, bp);
    for (int i = 0; i < 3; i++) step(2'd2, 4'b0100, 1'b0, bp);
    step(2'd2, 4'b0000, 1'b1, bp);
    step(2'd2, 4'b0000, 1'b1, bp);

    // Drain and load on the same edge
    step(2'd0, 4'b0001, 1'b1, ramp);
    step(2'd1, 4'b0010, 1'b1, {32'h0, 32'h0, 32'hBEEF_0001, 32'h0});

`ifdef MUXN_RR_EN
    for (int i = 0; i < 6; i++) step(2'd0, 4'b1011, 1'b1, ramp);
    step(2'd0, 4'b0000, 1'b1, ramp);
`endif

    for (int i = 0; i < 300; i++)
      step(2'($urandom_range(0, 3)), 4'($urandom), ($urandom_range(0, 3) != 0),
           {$urandom, $urandom, $urandom, $urandom});

    // Mid-cycle reset while a word is held
    step(2'd3, 4'b1000, 1'b0, ramp);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_y_valid", y_valid, 1'b0);
    check("async_y", y, 32'h0);
    check("async_in_ready", in_ready, 4'h0);
    @(posedge clk);
    #1 check_out();
    @(negedge clk) rst_n = 1'b1;
    step(2'd1, 4'b0010, 1'b1, ramp);

`ifndef MUXN_RR_EN
    // N=3 instance: select 3 is out of range
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s3 = 2'd3; v3 = 3'b111; yr3 = 1'b1; bus3 = {8'h33, 8'h22, 8'h11};
      #1 check("n3_in_ready", rdy3, 3'b000);
      @(posedge clk);
      #1 check("n3_y_valid", yv3, 1'b0);
    end
    @(negedge clk);
    s3 = 2'd1;
    #1 check("n3_in_ready_s1", rdy3, 3'b010);
    @(posedge clk);
    #1;
    check("n3_y", y3, 8'h22);
    check("n3_y_ch", ych3, 2'd1);
    check("n3_y_valid_s1", yv3, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
